cx_issuer: RTL and testbench
============================

Name: cx_issuer

Overview:
- Command-side master for the cx ALU.
- Accepts operand/op commands on a valid/ready interface and buffers them in a command FIFO.
- Drives the ALU's a/b/op inputs one command per cycle, tracks the fixed ALU pipeline latency with a tag shift register, and captures each result into a response FIFO.
- Returns results in order on a valid/ready response interface with an error flag.

Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
- RSP_DEPTH, 4, response FIFO entries (power of 2, >=2)
- ALU_LATENCY, 2, clock edges from ALU operand sample to result update

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO can accept
- cmd_a  in  8  operand a
- cmd_b  in  8  operand b
- cmd_op  in  4  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor
- alu_a  out  8  registered operand a to ALU
- alu_b  out  8  registered operand b to ALU
- alu_op  out  4  registered opcode to ALU; 4'b1111 when idle
- alu_result  in  16  ALU result
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_result  out  16  result; 0 when rsp_err
- rsp_err  out  1  illegal opcode (>6) or divide by zero
- busy  out  1  any command queued, in flight, or unread

Behaviour:
- Reset (reset low, async):
  - Both FIFOs empty; tag pipe cleared.
  - alu_a/alu_b = 0, alu_op = 4'b1111.
  - rsp_valid, rsp_result, rsp_err, busy = 0.
  - cmd_ready forced 0 while reset is low.
- Command accept:
  - Push on edge with cmd_valid & cmd_ready.
  - cmd_ready = !cmd_full; no same-cycle full bypass.
  - Pointers wrap modulo CMD_DEPTH.
- Issue (credit check):
  - Pop the FIFO head on an edge when cmd FIFO is non-empty and in_flight + rsp_count < RSP_DEPTH.
  - Both in_flight and rsp_count are registered values; a same-cycle response pop frees credit only on the next cycle.
  - A response slot is therefore always reserved.
- Issue (ALU drive):
  - On an issue edge, alu_a/alu_b/alu_op load the head command.
  - On any non-issue edge they load 0/0/4'b1111; the ALU then outputs 0, which is ignored.
  - At most one issue per cycle.
- Error flag:
  - err = (op > 6) | (op == 3 & b == 0), computed at issue.
  - err is carried through the tag pipe alongside a valid bit.
- Capture:
  - A command issued on edge N has alu_result sampled on edge N+ALU_LATENCY+1.
  - The sampled value (forced to 0 if err) is pushed with err into the response FIFO.
  - The tag pipe is ALU_LATENCY+1 stages deep; in_flight counts set valid bits.
- Response:
  - rsp_valid = !rsp_empty; rsp_result/rsp_err show the head entry.
  - Pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle: count unchanged.
  - Capture never overflows, guaranteed by credit.
- Latency and ordering:
  - Minimum accept-to-rsp_valid is ALU_LATENCY+2 edges (4 at default).
  - Sustained throughput is 1 command/cycle while rsp_ready is held 1.
  - Responses are strictly in command order.
- busy = !cmd_empty | (in_flight != 0) | !rsp_empty.
- Reset mid-operation: in-flight and queued commands are discarded; no stale response appears after release.

Optional Feature:
- Macro: CX_ISSUER_STATS_EN.
- When defined, adds two output ports:
  - stat_issued (16 bits): saturating count of issues.
  - stat_errors (16 bits): saturating count of responses pushed with err = 1.
  - Both clear on reset.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Add: single command a=5, b=3, op=0 with rsp_ready=1 -> rsp_valid rises 4 edges after accept; rsp_result=0x0008, rsp_err=0.
- Back-to-back ops: mul 200*200, sub 3-5, div 7/2, xor 0xF0^0x0F on consecutive cycles -> 0x9C40, 0xFFFE, 0x0003, 0x00FF on consecutive cycles, in order.
- Backpressure: rsp_ready=0, offer 10 commands -> exactly 4 issued, 4 queued, cmd_ready=0, 2 held. Then rsp_ready=1 -> all 10 responses, none lost or duplicated.
- Errors: op=4'b1001, then div 9/0 -> both rsp_err=1, rsp_result=0x0000; next add 1+1 -> 0x0002, err=0.
- Reset mid-operation: assert reset with 2 commands in flight and 1 queued -> rsp_valid=0 and alu_op=4'b1111 immediately. After release, busy=0 and no response appears within 10 cycles.
- Stats (CX_ISSUER_STATS_EN defined): run the error scenario -> stat_issued=3, stat_errors=2.

Source files
------------

// File: rtl/cx_issuer.sv
// cx_issuer: command FIFO -> credit-checked ALU issue -> latency-tracked capture -> response FIFO; stats ports under CX_ISSUER_STATS_EN
module cx_issuer #(
  parameter int CMD_DEPTH   = 4,
  parameter int RSP_DEPTH   = 4,
  parameter int ALU_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [3:0]  cmd_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
`ifdef CX_ISSUER_STATS_EN
  output logic        busy,
  output logic [15:0] stat_issued,
  output logic [15:0] stat_errors
`else
  output logic        busy
`endif
);
  localparam int CW = $clog2(CMD_DEPTH);
  localparam int RW = $clog2(RSP_DEPTH);
  localparam int TD = ALU_LATENCY + 1;
  logic [19:0]   cmd_mem [CMD_DEPTH];
  logic [CW-1:0] cmd_wp, cmd_rp;
  logic [CW:0]   cmd_cnt;
  logic [16:0]   rsp_mem [RSP_DEPTH];
  logic [RW-1:0] rsp_wp, rsp_rp;
  logic [RW:0]   rsp_cnt, in_flight;
  logic [TD-1:0] tag_v, tag_e;
  logic [19:0]   hd;
  logic          push, issue, hd_err, cap, pop;
  assign hd        = cmd_mem[cmd_rp];
  assign cmd_ready = reset && cmd_cnt != (CW+1)'(CMD_DEPTH);
  assign push      = cmd_valid && cmd_ready;
  assign issue     = cmd_cnt != '0 && ((RW+2)'(in_flight) + (RW+2)'(rsp_cnt) < (RW+2)'(RSP_DEPTH));
  assign hd_err    = hd[3:0] > 4'd6 || (hd[3:0] == 4'd3 && hd[11:4] == 8'd0);
  assign cap       = tag_v[TD-1];
  assign rsp_valid = rsp_cnt != '0;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_result = rsp_valid ? rsp_mem[rsp_rp][15:0] : '0;
  assign rsp_err   = rsp_valid && rsp_mem[rsp_rp][16];
  assign busy      = cmd_cnt != '0 || in_flight != '0 || rsp_valid;
  // FIFO storage: commands on accept, results (zeroed on error) on capture
  always_ff @(posedge clk) begin
    if (push) cmd_mem[cmd_wp] <= {cmd_a, cmd_b, cmd_op};
    if (cap) rsp_mem[rsp_wp] <= {tag_e[TD-1], tag_e[TD-1] ? 16'h0 : alu_result};
  end
  // pointers, counts, tag pipe and registered ALU drive
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_wp    <= '0;
      cmd_rp    <= '0;
      cmd_cnt   <= '0;
      rsp_wp    <= '0;
      rsp_rp    <= '0;
      rsp_cnt   <= '0;
      in_flight <= '0;
      tag_v     <= '0;
      tag_e     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 4'hF;
    end else begin
      cmd_wp    <= cmd_wp + CW'(push);
      cmd_rp    <= cmd_rp + CW'(issue);
      cmd_cnt   <= cmd_cnt + (CW+1)'(push) - (CW+1)'(issue);
      rsp_wp    <= rsp_wp + RW'(cap);
      rsp_rp    <= rsp_rp + RW'(pop);
      rsp_cnt   <= rsp_cnt + (RW+1)'(cap) - (RW+1)'(pop);
      in_flight <= in_flight + (RW+1)'(issue) - (RW+1)'(cap);
      tag_v     <= {tag_v[TD-2:0], issue};
      tag_e     <= {tag_e[TD-2:0], issue && hd_err};
      alu_a     <= issue ? hd[19:12] : '0;
      alu_b     <= issue ? hd[11:4] : '0;
      alu_op    <= issue ? hd[3:0] : 4'hF;
    end
  end
`ifdef CX_ISSUER_STATS_EN
  // saturating issue and error-response counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_issued <= '0;
      stat_errors <= '0;
    end else begin
      stat_issued <= stat_issued + 16'(issue && stat_issued != 16'hFFFF);
      stat_errors <= stat_errors + 16'(cap && tag_e[TD-1] && stat_errors != 16'hFFFF);
    end
  end
`endif
endmodule

// File: tb/tb_cx_issuer.sv
// tb_cx_issuer: randomized and directed checks of cx_issuer against a queue-based reference model
module tb_cx_issuer;
  logic clk = 0, reset = 1, cmd_valid = 0, rsp_ready = 0;
  logic [7:0] cmd_a = 0, cmd_b = 0;
  logic [3:0] cmd_op = 0;
  logic cmd_ready, rsp_valid, rsp_err, busy;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_op;
  logic [15:0] alu_result, rsp_result;
  logic [15:0] alu_p0 = '0, alu_p1 = '0;
`ifdef CX_ISSUER_STATS_EN
  logic [15:0] stat_issued, stat_errors;
`endif
  int total = 0, bad = 0;
  logic [16:0] exp_q[$];
  bit acc, popd;
  logic [16:0] got;

  cx_issuer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
`ifdef CX_ISSUER_STATS_EN
    .busy(busy), .stat_issued(stat_issued), .stat_errors(stat_errors)
`else
    .busy(busy)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    case (op)
      4'd0: return 16'(a) + 16'(b);
      4'd1: return 16'(a) - 16'(b);
      4'd2: return 16'(a) * 16'(b);
      4'd3: return b == 0 ? 16'hFFFF : 16'(a / b);
      4'd4: return 16'(a & b);
      4'd5: return 16'(a | b);
      4'd6: return 16'(a ^ b);
      default: return 16'h0;
    endcase
  endfunction

  function automatic logic [16:0] ref_rsp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic err;
    err = op > 4'd6 || (op == 4'd3 && b == 8'd0);
    return {err, err ? 16'h0 : alu_f(a, b, op)};
  endfunction

  // external ALU: result appears ALU_LATENCY edges after the operands are driven
  always @(posedge clk) begin
    alu_p0 <= alu_f(alu_a, alu_b, alu_op);
    alu_p1 <= alu_p0;
  end
  assign alu_result = alu_p1;

  task automatic step();
    @(negedge clk);
    acc = cmd_valid && cmd_ready;
    popd = rsp_valid && rsp_ready;
    got = {rsp_err, rsp_result};
    if (acc) exp_q.push_back(ref_rsp(cmd_a, cmd_b, cmd_op));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_valid = 0;
    reset = 0;
    @(posedge clk);
    #3 reset = 1;
    @(posedge clk);
    #1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    #2 reset = 0;
    #1;
    total++;
    if ({cmd_ready, rsp_valid, rsp_err, busy, alu_op, alu_a, alu_b, rsp_result} !== {4'b0, 4'hF, 32'h0}) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", {cmd_ready, rsp_valid, rsp_err, busy, alu_op, alu_a, alu_b, rsp_result}, {4'b0, 4'hF, 32'h0});
    end
    @(posedge clk);
    #3 reset = 1;
    @(posedge clk);
    #1;
    total++;
    if ({cmd_ready, busy} !== 2'b10) begin bad++; $display("FAIL reset_release got=%b want=10", {cmd_ready, busy}); end
  endtask

  task automatic test_add();
    int n;
    logic [16:0] e;
    rsp_ready = 1;
    {cmd_a, cmd_b, cmd_op} = {8'd5, 8'd3, 4'd0};
    cmd_valid = 1;
    step();
    cmd_valid = 0;
    total++;
    if (!acc) begin bad++; $display("FAIL add_accept got=0 want=1"); end
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) begin
        total++;
        if ({alu_a, alu_b, alu_op} !== {8'd5, 8'd3, 4'd0}) begin bad++; $display("FAIL add_drive got=%h want=%h", {alu_a, alu_b, alu_op}, {8'd5, 8'd3, 4'd0}); end
      end
    end while (!rsp_valid && n < 20);
    total++;
    if (n != 4) begin bad++; $display("FAIL add_latency got=%0d want=4", n); end
    step();
    e = exp_q.size() != 0 ? exp_q.pop_front() : 17'h1FFFF;
    total++;
    if (!popd || got !== 17'h00008 || e !== 17'h00008) begin bad++; $display("FAIL add_result got=%h want=00008", got); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL add_idle got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] cmds[4] = '{{8'd200, 8'd200, 4'd2}, {8'd3, 8'd5, 4'd1}, {8'd7, 8'd2, 4'd3}, {8'hF0, 8'h0F, 4'd6}};
    logic [16:0] want[4] = '{17'h09C40, 17'h0FFFE, 17'h00003, 17'h000FF};
    int np, first, last;
    logic [16:0] e;
    rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      {cmd_a, cmd_b, cmd_op} = cmds[i];
      cmd_valid = 1;
      step();
      total++;
      if (!acc) begin bad++; $display("FAIL b2b_accept%0d got=0 want=1", i); end
    end
    cmd_valid = 0;
    np = 0; first = 0; last = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (popd) begin
        e = exp_q.size() != 0 ? exp_q.pop_front() : 17'h1FFFF;
        total++;
        if (np >= 4 || got !== want[np] || e !== want[np]) begin bad++; $display("FAIL b2b_result%0d got=%h model=%h", np, got, e); end
        if (np == 0) first = c;
        last = c;
        np++;
      end
    end
    total++;
    if (np != 4 || last - first != 3) begin bad++; $display("FAIL b2b_spacing got=%0d/%0d want=4/3", np, last - first); end
  endtask

  task automatic test_backpressure();
    logic [19:0] cmds[10];
    int idx, issued, np, n;
    logic [16:0] e;
    for (int i = 0; i < 10; i++) cmds[i] = {8'($urandom), 8'($urandom_range(1, 255)), 4'($urandom_range(0, 6))};
    rsp_ready = 0;
    idx = 0; issued = 0;
    for (int c = 0; c < 12; c++) begin
      cmd_valid = idx < 10;
      {cmd_a, cmd_b, cmd_op} = cmds[idx % 10];
      step();
      if (acc) idx++;
      if (alu_op != 4'hF) issued++;
    end
    total++;
    if ({idx, issued} !== {32'd8, 32'd4}) begin bad++; $display("FAIL bp_counts got=%0d/%0d want=8/4", idx, issued); end
    total++;
    if ({cmd_ready, rsp_valid, busy} !== 3'b011) begin bad++; $display("FAIL bp_flags got=%b want=011", {cmd_ready, rsp_valid, busy}); end
    rsp_ready = 1;
    np = 0; n = 0;
    while ((idx < 10 || exp_q.size() != 0) && n < 100) begin
      cmd_valid = idx < 10;
      {cmd_a, cmd_b, cmd_op} = cmds[idx % 10];
      step();
      if (acc) idx++;
      if (popd) begin
        e = exp_q.size() != 0 ? exp_q.pop_front() : 17'h1FFFF;
        total++;
        if (got !== e) begin bad++; $display("FAIL bp_result%0d got=%h want=%h", np, got, e); end
        np++;
      end
      n++;
    end
    cmd_valid = 0;
    total++;
    if (np != 10) begin bad++; $display("FAIL bp_drain got=%0d want=10", np); end
  endtask

  task automatic test_errors();
    logic [19:0] cmds[3];
    logic [16:0] want[3] = '{17'h10000, 17'h10000, 17'h00002};
    int np;
    logic [16:0] e;
    cmds = '{{8'($urandom), 8'($urandom), 4'b1001}, {8'd9, 8'd0, 4'd3}, {8'd1, 8'd1, 4'd0}};
    do_reset();
    rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      {cmd_a, cmd_b, cmd_op} = cmds[i];
      cmd_valid = 1;
      step();
    end
    cmd_valid = 0;
    np = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (popd) begin
        e = exp_q.size() != 0 ? exp_q.pop_front() : 17'h1FFFF;
        total++;
        if (np >= 3 || got !== want[np] || e !== want[np]) begin bad++; $display("FAIL err_result%0d got=%h model=%h", np, got, e); end
        np++;
      end
    end
    total++;
    if (np != 3) begin bad++; $display("FAIL err_count got=%0d want=3", np); end
`ifdef CX_ISSUER_STATS_EN
    total++;
    if ({stat_issued, stat_errors} !== {16'd3, 16'd2}) begin bad++; $display("FAIL stats got=%0d/%0d want=3/2", stat_issued, stat_errors); end
`endif
  endtask

  task automatic test_random();
    logic [16:0] e;
    for (int c = 0; c < 400; c++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_a = 8'($urandom);
      cmd_b = $urandom_range(0, 4) == 0 ? 8'd0 : 8'($urandom);
      cmd_op = 4'($urandom_range(0, 15));
      rsp_ready = $urandom_range(0, 3) != 0;
      step();
      if (popd) begin
        e = exp_q.size() != 0 ? exp_q.pop_front() : 17'h1FFFF;
        total++;
        if (got !== e) begin bad++; $display("FAIL rand_result got=%h want=%h", got, e); end
      end
    end
    cmd_valid = 0;
    rsp_ready = 1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (popd) begin
        e = exp_q.size() != 0 ? exp_q.pop_front() : 17'h1FFFF;
        total++;
        if (got !== e) begin bad++; $display("FAIL rand_drain got=%h want=%h", got, e); end
      end
    end
    total++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL rand_empty got=%0d/%b want=0/0", exp_q.size(), busy); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      {cmd_a, cmd_b, cmd_op} = {8'(i + 1), 8'd2, 4'd0};
      cmd_valid = 1;
      step();
    end
    cmd_valid = 0;
    total++;
    if ({busy, alu_op} !== {1'b1, 4'd0}) begin bad++; $display("FAIL mid_preload got=%h want=10", {busy, alu_op}); end
    reset = 0;
    #1;
    total++;
    if ({rsp_valid, alu_op, cmd_ready, busy} !== {1'b0, 4'hF, 2'b00}) begin bad++; $display("FAIL mid_reset got=%h want=3c", {rsp_valid, alu_op, cmd_ready, busy}); end
    @(posedge clk);
    #3 reset = 1;
    exp_q.delete();
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (rsp_valid || busy) seen = 1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL mid_stale got=1 want=0"); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
